// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encoding for requesters of alu_arbiter.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_ADDW   = 4'd2,
        ALU_SUBW   = 4'd3,
        ALU_AND    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_XOR    = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_SLT    = 4'd10,
        ALU_SLTU   = 4'd11,
        ALU_SH1ADD = 4'd12,
        ALU_SH2ADD = 4'd13,
        ALU_SH3ADD = 4'd14
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// with a registered response slot per requester.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][63:0]        req_operand_a,
    input  logic [NUM_REQ-1:0][63:0]        req_operand_b,
    input  alu_op_t [NUM_REQ-1:0]           req_alu_op,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [NUM_REQ-1:0][63:0]        rsp_result,
    output logic [NUM_REQ-1:0][TAG_W-1:0]   rsp_tag,
    output logic [63:0]                     alu_operand_a,
    output logic [63:0]                     alu_operand_b,
    output alu_op_t                         alu_op,
    input  logic [63:0]                     alu_result,
    output logic [IDX_W-1:0]                grant_idx
);

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               have_grant;
    int                 sel;

    // A full slot being drained this cycle can accept a new result on the same edge.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        grant_idx = '0;
        sel       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = int'(rr_ptr) + k;
            if (sel >= NUM_REQ) sel = sel - NUM_REQ;
            if (!found && eligible[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = IDX_W'(sel);
            end
        end
    end

    // Nothing is accepted while reset is asserted, even if requests are presented.
    assign have_grant = found & rst_n;
    assign req_ready  = grant & {NUM_REQ{rst_n}};

    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_op        = ALU_ADD;
        if (have_grant) begin
            alu_operand_a = req_operand_a[grant_idx];
            alu_operand_b = req_operand_b[grant_idx];
            alu_op        = req_alu_op[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (have_grant) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Refill takes priority over drain so a slot can turn over every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    rsp_valid[i]  <= 1'b1;
                    rsp_result[i] <= alu_result;
                    rsp_tag[i]    <= req_tag[i];
                end else if (rsp_ready[i]) begin
                    rsp_valid[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hung off the shared port.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][63:0]     req_operand_a;
    logic [1:0][63:0]     req_operand_b;
    alu_op_t [1:0]        req_alu_op;
    logic [1:0][3:0]      req_tag;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready;
    logic [1:0][63:0]     rsp_result;
    logic [1:0][3:0]      rsp_tag;
    logic [63:0]          alu_operand_a;
    logic [63:0]          alu_operand_b;
    alu_op_t              alu_op;
    logic [63:0]          alu_result;
    logic [0:0]           grant_idx;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NUM_REQ(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .req_alu_op(req_alu_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_op(alu_op), .alu_result(alu_result), .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] w_sum;
    always_comb begin
        w_sum = 32'd0;
        case (alu_op)
            ALU_SUB:    alu_result = alu_operand_a - alu_operand_b;
            ALU_ADDW: begin
                w_sum      = alu_operand_a[31:0] + alu_operand_b[31:0];
                alu_result = {{32{w_sum[31]}}, w_sum};
            end
            ALU_SUBW: begin
                w_sum      = alu_operand_a[31:0] - alu_operand_b[31:0];
                alu_result = {{32{w_sum[31]}}, w_sum};
            end
            ALU_AND:    alu_result = alu_operand_a & alu_operand_b;
            ALU_OR:     alu_result = alu_operand_a | alu_operand_b;
            ALU_XOR:    alu_result = alu_operand_a ^ alu_operand_b;
            ALU_SH1ADD: alu_result = (alu_operand_a << 1) + alu_operand_b;
            ALU_SH2ADD: alu_result = (alu_operand_a << 2) + alu_operand_b;
            ALU_SH3ADD: alu_result = (alu_operand_a << 3) + alu_operand_b;
            default:    alu_result = alu_operand_a + alu_operand_b;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input alu_op_t op, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] t);
        req_alu_op[i]    = op;
        req_operand_a[i] = a;
        req_operand_b[i] = b;
        req_tag[i]       = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 2'b00;
        rsp_ready     = 2'b00;
        req_operand_a = '0;
        req_operand_b = '0;
        req_alu_op    = {ALU_ADD, ALU_ADD};
        req_tag       = '0;

        // Test 1: single ADD, request already presented while in reset.
        set_req(0, ALU_ADD, 64'd5, 64'd7, 4'd3);
        req_valid = 2'b01;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_result0", rsp_result[0], 64'd0);
        chk("rst_tag0", 64'(rsp_tag[0]), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'd1);
        chk("t1_gidx", 64'(grant_idx), 64'd0);
        chk("t1_alu_a", alu_operand_a, 64'd5);
        chk("t1_alu_b", alu_operand_b, 64'd7);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_result", rsp_result[0], 64'd12);
        chk("t1_tag", 64'(rsp_tag[0]), 64'd3);
        chk("idle_ready", 64'(req_ready), 64'd0);
        chk("idle_alu_a", alu_operand_a, 64'd0);
        chk("idle_alu_op", 64'(alu_op), 64'(ALU_ADD));
        tick();
        @(negedge clk);
        chk("t1_hold_valid", 64'(rsp_valid), 64'd1);
        chk("t1_hold_result", rsp_result[0], 64'd12);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("t1_drained", 64'(rsp_valid), 64'd0);

        // Tests 2/3: both requesters continuously valid, responses always consumed.
        do_reset();
        set_req(0, ALU_ADD, 64'd1, 64'd1, 4'd1);
        set_req(1, ALU_ADD, 64'd2, 64'd2, 4'd2);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("alt_gidx%0d", k), 64'(grant_idx), 64'(k % 2));
            chk($sformatf("alt_ready%0d", k), 64'(req_ready), 64'(1 << (k % 2)));
            if (k > 0) begin
                chk($sformatf("alt_rspv%0d", k), 64'(rsp_valid), 64'(1 << ((k - 1) % 2)));
                chk($sformatf("alt_res%0d", k), rsp_result[(k - 1) % 2],
                    ((k - 1) % 2 == 0) ? 64'd2 : 64'd4);
            end
            tick();
        end

        // Test 4: slot 0 held full blocks req0; req1 streams; then drain+refill.
        do_reset();
        set_req(0, ALU_ADD, 64'd10, 64'd20, 4'd5);
        req_valid = 2'b01;
        @(negedge clk);
        chk("t4_first", 64'(req_ready), 64'd1);
        tick();
        set_req(1, ALU_ADD, 64'd3, 64'd4, 4'd6);
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_ready%0d", k), 64'(req_ready), 64'd2);
            chk($sformatf("t4_stall_res%0d", k), rsp_result[0], 64'd30);
            chk($sformatf("t4_stall_tag%0d", k), 64'(rsp_tag[0]), 64'd5);
            tick();
        end
        chk("t4_r1_result", rsp_result[1], 64'd7);
        chk("t4_r1_tag", 64'(rsp_tag[1]), 64'd6);
        rsp_ready = 2'b11;
        set_req(0, ALU_ADD, 64'd100, 64'd1, 4'd7);
        @(negedge clk);
        chk("t4_refill_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t4_refill_valid", 64'(rsp_valid[0]), 64'd1);
        chk("t4_refill_res", rsp_result[0], 64'd101);
        chk("t4_refill_tag", 64'(rsp_tag[0]), 64'd7);

        // Test 5: results come from the ALU unchanged.
        do_reset();
        set_req(1, ALU_SH2ADD, 64'd3, 64'd100, 4'd9);
        req_valid = 2'b10;
        @(negedge clk);
        chk("t5_gidx1", 64'(grant_idx), 64'd1);
        tick();
        set_req(0, ALU_SUBW, 64'd0, 64'd1, 4'd4);
        req_valid = 2'b01;
        @(negedge clk);
        chk("t5_sh2add", rsp_result[1], 64'd112);
        chk("t5_gidx0", 64'(grant_idx), 64'd0);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t5_subw", rsp_result[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5_both_full", 64'(rsp_valid), 64'd3);

        // Test 6: asynchronous reset mid-stream.
        req_valid = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_res1", rsp_result[1], 64'd0);
        chk("t6_ready_in_rst", 64'(req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        set_req(0, ALU_ADD, 64'd8, 64'd9, 4'd1);
        set_req(1, ALU_ADD, 64'd1, 64'd1, 4'd2);
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("t6_first_gidx", 64'(grant_idx), 64'd0);
        chk("t6_first_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t6_res0", rsp_result[0], 64'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
